count_zeros_sched: RTL
======================

Name: count_zeros_sched

Overview:
Round-robin scheduler that shares one 32-bit zero-count unit (`count_zeros`, 1-cycle registered latency) between N_REQ requesters. Each requester uses a valid/ready handshake. Every accepted word is tagged with its requester id. Results return through a credit-protected response FIFO with consumer backpressure; the count unit itself never stalls.

Parameters:
N_REQ, 4, number of requesters (2..8).
RSP_DEPTH, 4, response FIFO entries (power of 2, >=2).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-high reset.
req_valid  in  N_REQ  per-requester request valid.
req_x  in  N_REQ x 32  per-requester operand word.
req_ready  out  N_REQ  one-hot grant; handshake when req_valid[i] & req_ready[i].
rsp_valid  out  1  response FIFO head valid.
rsp_ready  in  1  consumer accepts head.
rsp_id  out  $clog2(N_REQ)  requester id of head.
rsp_y  out  6  zero count of head word, range 0..32.
busy  out  1  inflight_r | FIFO non-empty.

Behaviour:
- Reset (async, active-high):
  - Clears rr_ptr, inflight_r, id_r, FIFO pointers and count.
  - Outputs during/after reset: req_ready=0, rsp_valid=0, rsp_id=0, rsp_y=0, busy=0.
  - req_ready is forced 0 while rst=1, regardless of req_valid.
- Credit:
  - Issue is allowed iff fifo_cnt_r + inflight_r < RSP_DEPTH.
  - The credit check uses registered values only; a pop in the same cycle does not free a credit until the next cycle.
- Arbitration (combinational):
  - When issue is allowed, grant the first set req_valid[i] searching from rr_ptr upward, wrapping modulo N_REQ.
  - At most one req_ready bit is high. req_ready[i] is never high unless req_valid[i] is high.
  - No grant: rr_ptr holds. On grant to g: rr_ptr <= (g+1) mod N_REQ.
- Issue (cycle c):
  - Drive unit pass=1, x=req_x[g]; id_r <= g; inflight_r <= 1.
  - No grant: pass=0, inflight_r <= 0.
- Completion (cycle c+1):
  - inflight_r=1 and the unit output is valid. Push {id_r, y} into the FIFO at the end of c+1.
  - rsp_valid rises in cycle c+2. Fixed handshake-to-rsp_valid latency is 2 cycles.
- Validity tracking:
  - This block owns inflight_r and id_r (async reset).
  - The unit's own valid_r (sync reset) is ignored.
- FIFO:
  - rsp_valid = (fifo_cnt_r != 0). Pop on rsp_valid & rsp_ready.
  - Simultaneous push/pop leaves the count unchanged.
  - Pointers wrap modulo RSP_DEPTH.
  - rsp_id and rsp_y are gated to 0 when rsp_valid=0.
- Overflow:
  - Impossible by the credit rule.
  - Assertions: push when full never occurs; pop when empty never occurs; req_ready is onehot0.
- Throughput: with rsp_ready held high, one request per cycle is sustained indefinitely.
- Ordering: responses leave in issue order; there is no per-requester reordering.
- Reset mid-operation: in-flight and queued results are discarded. No response from before reset ever appears after deassertion.

Decomposition:
- Package count_zeros_pkg: w_t (32b), w_cnt_t (6b), req_id_t ($clog2(N_REQ)), packed struct rsp_t {req_id_t id; w_cnt_t y;}, constant W=32.
- Sub-module: instantiate the existing `count_zeros` unit as the datapath. Its rst is tied to this block's rst; its valid_r is left unused.
- The FIFO stays inline (small, credit-protected).

Test Plan:
1. Single request, req_valid[2]=1, x=0x00000000, rsp_ready=1. Required: req_ready=4'b0100 in cycle c; rsp_valid in c+2 with rsp_id=2, rsp_y=32; busy low again in c+3.
2. Values x=0xFFFFFFFF, 0x0000FFFF, 0x80000001 from requester 0 back-to-back. Required: rsp_y = 0, 16, 30 on consecutive cycles from c+2, all with rsp_id=0.
3. All four requesters valid continuously, rsp_ready=1. Required: grants 0,1,2,3,0,1... one per cycle; rsp_id follows the same sequence 2 cycles later.
4. rsp_ready=0 with requesters 1 and 3 valid. Required: exactly 4 handshakes (ids 1,3,1,3), then req_ready=0. Raise rsp_ready: first pop in that cycle, next grant the following cycle, ids keep alternating.
5. FIFO full, pop and request in the same cycle. Required: no grant that cycle; grant in the next cycle; no overflow assertion fires.
6. Assert rst asynchronously mid-stream with 1 in flight and 3 queued. Required: rsp_valid, req_ready and busy drop immediately. After release, no stale response appears; the first new grant goes to requester 0.

Source files
------------

// File: rtl/count_zeros_pkg.sv
// Shared types for the zero-count scheduler and its datapath unit.
package count_zeros_pkg;

  localparam int W         = 32;
  localparam int CNT_W     = 6;
  // Ids are stored at the widest supported requester count; the top slices
  // down to $clog2(N_REQ) on its output port.
  localparam int N_REQ_MAX = 8;
  localparam int ID_W      = $clog2(N_REQ_MAX);

  typedef logic [W-1:0]     w_t;
  typedef logic [CNT_W-1:0] w_cnt_t;
  typedef logic [ID_W-1:0]  req_id_t;

  typedef struct packed {
    req_id_t id;
    w_cnt_t  y;
  } rsp_t;

  // Number of zero bits in a word, 0..32.
  function automatic w_cnt_t zeros_of(w_t x);
    w_cnt_t n;
    n = '0;
    for (int i = 0; i < W; i++) begin
      if (!x[i]) n = n + w_cnt_t'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/count_zeros.sv
// Zero-count unit: one word in, its zero count out one cycle later.
// Never stalls; valid_r follows pass with a synchronous reset.
module count_zeros
  import count_zeros_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   pass,
  input  w_t     x,
  output w_cnt_t y,
  output logic   valid_r
);

  w_cnt_t y_q;
  logic   valid_q;

  // Capture the count of the word presented this cycle.
  always_ff @(posedge clk) begin
    if (pass) y_q <= zeros_of(x);
  end

  // Track which output cycles carry a fresh result.
  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= pass;
  end

  assign y       = y_q;
  assign valid_r = valid_q;

endmodule

// File: rtl/count_zeros_sched.sv
// Round-robin scheduler sharing one count_zeros unit among N_REQ requesters.
// A grant is only issued when the response FIFO is guaranteed to have room
// for it (queued + in-flight < depth), so the unit never has to stall.
module count_zeros_sched
  import count_zeros_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0][W-1:0]    req_x,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [CNT_W-1:0]           rsp_y,
  output logic                       busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam int PW  = $clog2(RSP_DEPTH);
  localparam int CW  = PW + 1;

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           inflight_q;
  logic [IDW-1:0] id_q;
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  rsp_t           mem_q [RSP_DEPTH];

  logic           credit_ok;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_idx;
  w_t             unit_x;
  w_cnt_t         unit_y;
  logic           unused_unit_vld;
  logic           push, pop;
  rsp_t           head;

  // Registered values only: a pop this cycle frees its credit next cycle.
  assign credit_ok = (cnt_q + CW'(inflight_q)) < CW'(RSP_DEPTH);

  // Round-robin search from rr_ptr, wrapping; no grants while in reset.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (credit_ok && !rst) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!gnt_vld && req_valid[(int'(rr_ptr_q) + k) % N_REQ]) begin
          gnt_vld = 1'b1;
          gnt_idx = IDW'((int'(rr_ptr_q) + k) % N_REQ);
        end
      end
    end
  end

  // One-hot ready and the next round-robin start point.
  always_comb begin
    req_ready = '0;
    rr_ptr_d  = rr_ptr_q;
    if (gnt_vld) begin
      req_ready[gnt_idx] = 1'b1;
      rr_ptr_d = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end
  end

  assign unit_x = req_x[gnt_idx];

  count_zeros u_cz (
    .clk     (clk),
    .rst     (rst),
    .pass    (gnt_vld),
    .x       (unit_x),
    .y       (unit_y),
    .valid_r (unused_unit_vld)
  );

  // Issue tracking: the word granted now has its count ready next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      inflight_q <= 1'b0;
      id_q       <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= gnt_vld;
      if (gnt_vld) id_q <= gnt_idx;
    end
  end

  assign push = inflight_q;
  assign pop  = rsp_valid & rsp_ready;

  // Occupancy: simultaneous push and pop cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  // FIFO pointers and count; reset drops every queued result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; the count decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{id: req_id_t'(id_q), y: unit_y};
  end

  assign head      = mem_q[rd_ptr_q];
  assign rsp_valid = (cnt_q != '0);
  assign rsp_id    = rsp_valid ? head.id[IDW-1:0] : '0;
  assign rsp_y     = rsp_valid ? head.y : '0;
  assign busy      = inflight_q | rsp_valid;

  generate
    if (IDW < ID_W) begin : g_id_hi
      logic unused_id_hi;
      assign unused_id_hi = ^head.id[ID_W-1:IDW];
    end
  endgenerate

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && cnt_q == CW'(RSP_DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && cnt_q == '0));
  a_ready_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready));
  a_ready_has_valid: assert property (@(posedge clk) disable iff (rst)
    (req_ready & ~req_valid) == '0);

endmodule
